// File: rtl/lapido_pkg.sv
// Shared definitions for the Lapido core: instruction classes, the idle instruction
// word and the fetch FSM state encoding.
package lapido_pkg;

  localparam logic [2:0] CLASS_NOP   = 3'b000;
  localparam logic [2:0] CLASS_ULA   = 3'b001;
  localparam logic [2:0] CLASS_CONST = 3'b010;
  localparam logic [2:0] CLASS_MEM   = 3'b100;
  localparam logic [2:0] CLASS_CTRL  = 3'b101;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

  function automatic logic [2:0] inst_class(input logic [31:0] word);
    return word[31:29];
  endfunction

endpackage

// File: rtl/lapido_pc_register.sv
// Program counter with redirect mux, +1 incrementer and reset load.
// pc_next is the value the register will take at the next edge (reset excluded).
module lapido_pc_register #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc_plus1
);

  assign pc_plus1 = pc + 1'b1;

  always_comb begin
    pc_next = pc;
    if (load)
      pc_next = target;
    else if (inc)
      pc_next = pc_plus1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/lapido_fetch_unit.sv
// Lapido instruction fetch stage: req/ack handshake with instruction memory,
// instruction register towards the decoder, redirect squashing and access timeout.
module lapido_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_WORD = lapido_pkg::NOP_WORD,
  parameter int unsigned       TIMEOUT  = 64
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic              inst_valid,
  input  logic              decode_ready,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              fetch_fault
);

  import lapido_pkg::*;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  fetch_state_t      state;
  logic [7:0]        wait_cnt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_inc;
  logic              ack;
  logic              accept;

  assign ack    = imem_ack && imem_req;
  assign accept = (state == S_REQ) && ack && !redirect;

  lapido_pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock    (clock),
    .reset    (reset),
    .load     (redirect),
    .inc      (accept),
    .target   (redirect_target),
    .pc       (pc),
    .pc_next  (pc_next),
    .pc_plus1 (pc_inc)
  );

  // Every entry into REQ loads imem_addr from pc_next, so a redirect arriving on
  // that same edge is already reflected in the new request address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instruction <= NOP_WORD;
      inst_valid  <= 1'b0;
      pc_out      <= RESET_PC;
      pc_plus1    <= RESET_PC + 1'b1;
      fetch_fault <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (ack) begin
        wait_cnt <= '0;
      end else if (imem_req && wait_cnt < TMO) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt == TMO - 8'd1)
          fetch_fault <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (!stall) begin
            state     <= S_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_next;
          end
        end
        S_REQ: begin
          if (redirect) begin
            if (ack)
              imem_addr <= pc_next;
            else
              state <= S_DRAIN;
          end else if (ack) begin
            instruction <= imem_rdata;
            pc_out      <= pc;
            pc_plus1    <= pc_inc;
            inst_valid  <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect || (decode_ready && !stall)) begin
            inst_valid  <= 1'b0;
            instruction <= NOP_WORD;
            imem_req    <= 1'b1;
            imem_addr   <= pc_next;
            state       <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (ack) begin
            imem_addr <= pc_next;
            state     <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lapido_fetch_unit.sv
// Bench for lapido_fetch_unit: responder memory, scoreboard of expected fetched
// words popped on each rising inst_valid, plus per-scenario inline checks.
module tb_lapido_fetch_unit;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        decode_ready = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_target = '0;
  logic [15:0] pc_out;
  logic [15:0] pc_plus1;
  logic        fetch_fault;

  int   tests = 0;
  int   fails = 0;
  int   ack_delay = 1;
  bit   mem_hold = 1'b0;
  int   req_cnt = 0;
  bit   prev_valid = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] mon_p1;

  lapido_fetch_unit #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000),
    .NOP_WORD (32'h0000_0000),
    .TIMEOUT  (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instruction     (instruction),
    .inst_valid      (inst_valid),
    .decode_ready    (decode_ready),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc_out          (pc_out),
    .pc_plus1        (pc_plus1),
    .fetch_fault     (fetch_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'h2000_0000 | {16'h0000, a};
  endfunction

  function automatic exp_t mk(input logic [15:0] a);
    exp_t e;
    e.pc   = a;
    e.word = mem_word(a);
    return e;
  endfunction

  // Memory acks after req has been high for ack_delay earlier cycles.
  always @(negedge clock) begin
    if (reset || !imem_req) begin
      imem_ack = 1'b0;
      req_cnt  = 0;
    end else if (!mem_hold && req_cnt >= ack_delay) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      req_cnt    = 0;
    end else begin
      imem_ack = 1'b0;
      req_cnt++;
    end
  end

  always @(negedge clock) begin
    if (inst_valid === 1'b1 && !prev_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got pc_out=%h instruction=%h, required no valid word", pc_out, instruction);
      end else begin
        mon_e  = sb.pop_front();
        mon_p1 = mon_e.pc + 16'd1;
        if (instruction !== mon_e.word || pc_out !== mon_e.pc || pc_plus1 !== mon_p1) begin
          fails++;
          $display("FAIL sb_fetch: got pc_out=%h pc_plus1=%h instruction=%h, required %h %h %h",
                   pc_out, pc_plus1, instruction, mon_e.pc, mon_p1, mon_e.word);
        end
      end
    end
    prev_valid = (inst_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b1;
    decode_ready = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || inst_valid !== 1'b0 || instruction !== 32'h0) begin
      fails++;
      $display("FAIL reset_fetch: got req=%b addr=%h valid=%b instr=%h, required 0 0000 0 00000000",
               imem_req, imem_addr, inst_valid, instruction);
    end
    tests++;
    if (pc_out !== 16'h0000 || pc_plus1 !== 16'h0001 || fetch_fault !== 1'b0) begin
      fails++;
      $display("FAIL reset_pc: got pc_out=%h pc_plus1=%h fault=%b, required 0000 0001 0",
               pc_out, pc_plus1, fetch_fault);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    sb.push_back(mk(16'h0000));
    @(negedge clock);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      fails++;
      $display("FAIL basic_req_c1: got req=%b addr=%h, required 1 0000", imem_req, imem_addr);
    end
    sb.push_back(mk(16'h0001));
    @(negedge clock);
    tests++;
    if (inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_valid_c2: got %b, required 0", inst_valid);
    end
    @(negedge clock);
    tests++;
    if (inst_valid !== 1'b1 || pc_out !== 16'h0000 || pc_plus1 !== 16'h0001 || instruction !== 32'h2000_0000) begin
      fails++;
      $display("FAIL basic_valid_c3: got valid=%b pc_out=%h pc_plus1=%h instr=%h, required 1 0000 0001 20000000",
               inst_valid, pc_out, pc_plus1, instruction);
    end
    @(negedge clock);
    decode_ready = 1'b0;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
      fails++;
      $display("FAIL basic_req_c4: got req=%b addr=%h, required 1 0001", imem_req, imem_addr);
    end
  endtask

  task automatic test_hold();
    int n = 0;
    while (inst_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (inst_valid !== 1'b1 || instruction !== mem_word(16'h0001) || pc_out !== 16'h0001 || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable[%0d]: got valid=%b instr=%h pc_out=%h req=%b, required 1 %h 0001 0",
                 i, inst_valid, instruction, pc_out, imem_req, mem_word(16'h0001));
      end
      @(negedge clock);
    end
    sb.push_back(mk(16'h0002));
    decode_ready = 1'b1;
    @(negedge clock);
    decode_ready = 1'b0;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || inst_valid !== 1'b0 || instruction !== 32'h0) begin
      fails++;
      $display("FAIL hold_release: got req=%b addr=%h valid=%b instr=%h, required 1 0002 0 00000000",
               imem_req, imem_addr, inst_valid, instruction);
    end
    n = 0;
    while (inst_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    tests++;
    if (inst_valid !== 1'b1) begin
      fails++;
      $display("FAIL hold_refetch_timeout: got valid=%b, required 1", inst_valid);
    end
  endtask

  task automatic test_redirect_drain();
    int n = 0;
    ack_delay = 3;
    decode_ready = 1'b1;
    @(negedge clock);
    decode_ready = 1'b0;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0003) begin
      fails++;
      $display("FAIL drain_req: got req=%b addr=%h, required 1 0003", imem_req, imem_addr);
    end
    redirect = 1'b1;
    redirect_target = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      redirect = 1'b0;
      if (i == 2) begin
        ack_delay = 1;
        sb.push_back(mk(16'h0040));
      end
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0003 || inst_valid !== 1'b0) begin
        fails++;
        $display("FAIL drain_hold_addr[%0d]: got req=%b addr=%h valid=%b, required 1 0003 0",
                 i, imem_req, imem_addr, inst_valid);
      end
    end
    @(negedge clock);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_new_addr: got req=%b addr=%h valid=%b, required 1 0040 0",
               imem_req, imem_addr, inst_valid);
    end
    while (inst_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    tests++;
    if (inst_valid !== 1'b1 || pc_out !== 16'h0040) begin
      fails++;
      $display("FAIL drain_fetch: got valid=%b pc_out=%h, required 1 0040", inst_valid, pc_out);
    end
  endtask

  task automatic test_redirect_ack();
    int n = 0;
    decode_ready = 1'b1;
    @(negedge clock);
    decode_ready = 1'b0;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0041) begin
      fails++;
      $display("FAIL rack_req: got req=%b addr=%h, required 1 0041", imem_req, imem_addr);
    end
    @(negedge clock);
    redirect = 1'b1;
    redirect_target = 16'h0080;
    sb.push_back(mk(16'h0080));
    @(negedge clock);
    redirect = 1'b0;
    tests++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
      fails++;
      $display("FAIL rack_next: got valid=%b req=%b addr=%h, required 0 1 0080", inst_valid, imem_req, imem_addr);
    end
    while (inst_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    tests++;
    if (inst_valid !== 1'b1 || pc_out !== 16'h0080) begin
      fails++;
      $display("FAIL rack_fetch: got valid=%b pc_out=%h, required 1 0080", inst_valid, pc_out);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    redirect = 1'b1;
    redirect_target = 16'hFFFF;
    sb.push_back(mk(16'hFFFF));
    @(negedge clock);
    redirect = 1'b0;
    tests++;
    if (inst_valid !== 1'b0 || instruction !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_hold_redirect: got valid=%b instr=%h req=%b addr=%h, required 0 00000000 1 ffff",
               inst_valid, instruction, imem_req, imem_addr);
    end
    while (inst_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    tests++;
    if (inst_valid !== 1'b1 || pc_out !== 16'hFFFF || pc_plus1 !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_pc_plus1: got valid=%b pc_out=%h pc_plus1=%h, required 1 ffff 0000",
               inst_valid, pc_out, pc_plus1);
    end
    sb.push_back(mk(16'h0000));
    decode_ready = 1'b1;
    @(negedge clock);
    decode_ready = 1'b0;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_next_addr: got req=%b addr=%h, required 1 0000", imem_req, imem_addr);
    end
    n = 0;
    while (inst_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
  endtask

  task automatic test_timeout();
    int n = 0;
    mem_hold = 1'b1;
    sb.push_back(mk(16'h0001));
    decode_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      decode_ready = 1'b0;
      tests++;
      if (fetch_fault !== 1'b0 || imem_req !== 1'b1) begin
        fails++;
        $display("FAIL tmo_early[%0d]: got fault=%b req=%b, required 0 1", i, fetch_fault, imem_req);
      end
    end
    @(negedge clock);
    tests++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
      fails++;
      $display("FAIL tmo_fault: got fault=%b req=%b addr=%h, required 1 1 0001", fetch_fault, imem_req, imem_addr);
    end
    repeat (3) @(negedge clock);
    mem_hold = 1'b0;
    while (inst_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    tests++;
    if (inst_valid !== 1'b1 || pc_out !== 16'h0001 || fetch_fault !== 1'b1) begin
      fails++;
      $display("FAIL tmo_complete: got valid=%b pc_out=%h fault=%b, required 1 0001 1", inst_valid, pc_out, fetch_fault);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if (fetch_fault !== 1'b0 || inst_valid !== 1'b0 || imem_req !== 1'b0 || pc_out !== 16'h0000) begin
      fails++;
      $display("FAIL tmo_reset_clear: got fault=%b valid=%b req=%b pc_out=%h, required 0 0 0 0000",
               fetch_fault, inst_valid, imem_req, pc_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_timeout();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending fetches, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
